// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states and operand lane helpers.
// Requests are 2 lanes wide; lane i of each packed bus belongs to requester i.
package alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;

  localparam int NREQ  = 2;
  localparam int OP_W  = 8;
  localparam int DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

  function automatic logic [OP_W-1:0] op_lane(input logic [NREQ*OP_W-1:0] v, input logic idx);
    return idx ? v[2*OP_W-1:OP_W] : v[OP_W-1:0];
  endfunction

  function automatic logic [DAT_W-1:0] dat_lane(input logic [NREQ*DAT_W-1:0] v, input logic idx);
    return idx ? v[2*DAT_W-1:DAT_W] : v[DAT_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester wins; on contention the one not granted last wins.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one transaction in flight; response after ALU_LAT+2 cycles
// (1 cycle for unsupported opcodes). Holds the response until the winner's rsp_ready; no new accept meanwhile.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_opcode,
  input  logic [NREQ*DAT_W-1:0]  req_a,
  input  logic [NREQ*DAT_W-1:0]  req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DAT_W-1:0]       rsp_result,
  output logic                   rsp_err,
  output logic [OP_W-1:0]        alu_opcode,
  output logic [DAT_W-1:0]       alu_a,
  output logic [DAT_W-1:0]       alu_b,
  input  logic [DAT_W-1:0]       alu_result,
  output logic                   busy
);

  // The counter runs ALU_LAT-1 .. 0, one ISSUE cycle per count.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t           state;
  logic             last_grant;
  logic [3:0]       cnt;
  logic             win;
  logic [NREQ-1:0]  grant;
  logic             sel;
  logic [OP_W-1:0]  sel_op;
  logic [DAT_W-1:0] sel_a;
  logic [DAT_W-1:0] sel_b;
  logic             accept;

  rr_arbiter_2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel    = grant[1];
  assign sel_op = op_lane(req_opcode, sel);
  assign sel_a  = dat_lane(req_a, sel);
  assign sel_b  = dat_lane(req_b, sel);

  // Gated by rst so nothing looks accepted while the block is held in reset.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      win        <= 1'b0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            win        <= sel;
            last_grant <= sel;
            if (op_supported(sel_op)) begin
              alu_opcode <= sel_op;
              alu_a      <= sel_a;
              alu_b      <= sel_b;
              cnt        <= LAT_M1;
              state      <= ISSUE;
            end else begin
              // Unsupported: the ALU is never touched, answer with an error at once.
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= grant;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cnt == 4'd0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
          rsp_valid  <= win ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[win]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic last_m;

  // ALU_LAT = 1 instance
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_opcode;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [7:0]  alu_opcode;
  logic        rsp_err, busy;

  // ALU_LAT = 3 instance
  logic        rst_3;
  logic [1:0]  req_valid_3, req_ready_3, rsp_valid_3, rsp_ready_3;
  logic [15:0] req_opcode_3;
  logic [63:0] req_a_3, req_b_3;
  logic [31:0] rsp_result_3, alu_a_3, alu_b_3, alu_result_3;
  logic [7:0]  alu_opcode_3;
  logic        rsp_err_3, busy_3;

  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .busy(busy)
  );

  alu_arbiter #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst_3), .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_opcode(req_opcode_3), .req_a(req_a_3), .req_b(req_b_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_result(rsp_result_3), .rsp_err(rsp_err_3),
    .alu_opcode(alu_opcode_3), .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_result(alu_result_3), .busy(busy_3)
  );

  // Stand-in ALUs: result appears ALU_LAT clocks after the operands, stale before that.
  function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 8'h02) return a * b;
    return a + b;
  endfunction

  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    alu_result <= alu_model(alu_opcode, alu_a, alu_b);
    pipe3[0]   <= alu_model(alu_opcode_3, alu_a_3, alu_b_3);
    pipe3[1]   <= pipe3[0];
    pipe3[2]   <= pipe3[1];
  end
  assign alu_result_3 = pipe3[2];

  // Reference model
  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    case (op)
      8'h01: wide = {32'd0, a} + {32'd0, b};
      8'h02: wide = {32'd0, a} * {32'd0, b};
      default: wide = 64'd0;
    endcase
    return wide[31:0];
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  function automatic logic [7:0] rand_op();
    int s;
    s = $urandom_range(0, 4);
    if (s < 2) return 8'h01;
    if (s < 4) return 8'h02;
    return 8'($urandom);
  endfunction

  task automatic test_reset();
    rst = 1'b1; rst_3 = 1'b1;
    req_valid = 2'b11; req_opcode = 16'h0101; req_a = '0; req_b = '0; rsp_ready = 2'b00;
    req_valid_3 = 2'b00; req_opcode_3 = '0; req_a_3 = '0; req_b_3 = '0; rsp_ready_3 = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_result !== 32'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b exp 0/0", rsp_result, rsp_err); end
    checks++; if (alu_opcode !== 8'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu got %h %h %h exp zeros", alu_opcode, alu_a, alu_b); end
    checks++; if (busy !== 1'b0 || busy_3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0/0", busy, busy_3); end
    req_valid = 2'b00;
    rst = 1'b0; rst_3 = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    int lat;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_opcode = {8'h00, OP_ADD}; req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd7}; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00; last_m = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        checks++;
        if (alu_opcode !== OP_ADD || alu_a !== 32'd5 || alu_b !== 32'd7 || busy !== 1'b1) begin
          errors++; $display("FAIL add_issue got op %h a %h b %h busy %b exp 01 5 7 1", alu_opcode, alu_a, alu_b, busy);
        end
      end
    end while (rsp_valid == 2'b00 && lat < 40);
    checks++; if (lat != 3) begin errors++; $display("FAIL add_latency got %0d exp 3", lat); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_result !== 32'd12 || rsp_err !== 1'b0) begin errors++; $display("FAIL add_result got %0d/%b exp 12/0", rsp_result, rsp_err); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL add_done got %b/%b exp 00/0", rsp_valid, busy); end
  endtask

  task automatic test_arbitration();
    int lat, wt;
    logic w;
    logic [1:0] oh;
    logic [31:0] exp_res;
    @(negedge clk);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; last_m = 1'b1;
    rsp_ready = 2'b11;
    req_opcode = {OP_ADD, OP_MUL}; req_a = {32'd10, 32'd3}; req_b = {32'd20, 32'd4}; req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wt = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && wt < 10) begin @(negedge clk); wt++; end
      w = pick(2'b11, last_m);
      oh = w ? 2'b10 : 2'b01;
      exp_res = w ? ref_result(OP_ADD, 32'd10, 32'd20) : ref_result(OP_MUL, 32'd3, 32'd4);
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL arb_grant_%0d got %b exp %b", k, req_ready, oh); end
      @(posedge clk);
      last_m = w;
      lat = 0;
      do begin @(negedge clk); lat++; end while (rsp_valid == 2'b00 && lat < 40);
      checks++; if (lat != 3) begin errors++; $display("FAIL arb_latency_%0d got %0d exp 3", k, lat); end
      checks++; if (rsp_valid !== oh || rsp_result !== exp_res) begin errors++; $display("FAIL arb_rsp_%0d got %b %0d exp %b %0d", k, rsp_valid, rsp_result, oh, exp_res); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL arb_no_accept_in_rsp_%0d got %b exp 00", k, req_ready); end
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_unsupported();
    int lat;
    logic [7:0] op0;
    logic [31:0] a0, b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    op0 = alu_opcode; a0 = alu_a; b0 = alu_b;
    req_opcode = {8'h07, 8'h00}; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL unsup_req_ready got %b exp 10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00; last_m = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid == 2'b00 && lat < 40);
    checks++; if (lat != 1) begin errors++; $display("FAIL unsup_latency got %0d exp 1", lat); end
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_err !== 1'b1) begin errors++; $display("FAIL unsup_rsp got %b %h %b exp 10 0 1", rsp_valid, rsp_result, rsp_err); end
    checks++; if (alu_opcode !== op0 || alu_a !== a0 || alu_b !== b0) begin errors++; $display("FAIL unsup_alu_touched got %h %h %h exp %h %h %h", alu_opcode, alu_a, alu_b, op0, a0, b0); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] a0, b0, exp_res;
    a0 = $urandom; b0 = $urandom;
    exp_res = ref_result(OP_MUL, a0, b0);
    rsp_ready = 2'b00;
    @(negedge clk);
    req_opcode = {OP_ADD, OP_MUL}; req_a = {32'd1, a0}; req_b = {32'd1, b0}; req_valid = 2'b01;
    @(posedge clk); #1;
    last_m = 1'b0;
    req_valid = 2'b10; rsp_ready = 2'b10;
    req_opcode = 16'hFFFF; req_a = {$urandom, $urandom};
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid == 2'b00 && lat < 40);
    checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== exp_res || rsp_err !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d got v %b r %h e %b rdy %b busy %b exp 01 %h 0 00 1", i, rsp_valid, rsp_result, rsp_err, req_ready, busy, exp_res);
      end
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b10) begin errors++; $display("FAIL bp_release got v %b busy %b rdy %b exp 00 0 10", rsp_valid, busy, req_ready); end
    req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_opcode = {8'h00, OP_MUL}; req_a = {32'd0, 32'hFFFF_FFFF}; req_b = {32'd0, 32'd2}; req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || alu_opcode !== OP_MUL) begin errors++; $display("FAIL rmid_issue got busy %b op %h exp 1 02", busy, alu_opcode); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_err !== 1'b0 || busy !== 1'b0 ||
        alu_opcode !== 8'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rmid_reset got v %b r %h e %b busy %b alu %h %h %h exp all zero", rsp_valid, rsp_result, rsp_err, busy, alu_opcode, alu_a, alu_b);
    end
    rst = 1'b0; last_m = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid !== 2'b00) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_ghost_rsp got %0d cycles exp 0", seen); end
    req_opcode = {OP_MUL, OP_ADD}; req_a = {32'd9, 32'd1}; req_b = {32'd9, 32'd1}; req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_grant got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00; last_m = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid == 2'b00 && lat < 40);
    checks++; if (lat != 3 || rsp_valid !== 2'b01 || rsp_result !== 32'd2) begin errors++; $display("FAIL rmid_after got lat %0d v %b r %0d exp 3 01 2", lat, rsp_valid, rsp_result); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, d;
    logic [1:0] v, oh;
    logic w, exp_err;
    logic [7:0] ops [2];
    logic [31:0] as [2], bs [2], exp_res;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      v = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        ops[i] = rand_op(); as[i] = $urandom; bs[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      req_opcode = {ops[1], ops[0]}; req_a = {as[1], as[0]}; req_b = {bs[1], bs[0]}; req_valid = v;
      w = pick(v, last_m);
      oh = w ? 2'b10 : 2'b01;
      exp_res = ref_result(ops[w], as[w], bs[w]);
      exp_err = !(ops[w] == 8'h01 || ops[w] == 8'h02);
      #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL rnd_grant_%0d got %b exp %b", it, req_ready, oh); end
      @(posedge clk); #1;
      last_m = w;
      d = $urandom_range(0, 3);
      req_valid = 2'($urandom); req_opcode = 16'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      rsp_ready = (d == 0) ? 2'b11 : (2'($urandom) & ~oh);
      lat = 0;
      do begin @(negedge clk); lat++; end while (rsp_valid == 2'b00 && lat < 40);
      checks++; if (lat != (exp_err ? 1 : 3)) begin errors++; $display("FAIL rnd_latency_%0d got %0d exp %0d", it, lat, exp_err ? 1 : 3); end
      checks++; if (rsp_valid !== oh || rsp_result !== exp_res || rsp_err !== exp_err) begin errors++; $display("FAIL rnd_rsp_%0d got %b %h %b exp %b %h %b", it, rsp_valid, rsp_result, rsp_err, oh, exp_res, exp_err); end
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        checks++; if (rsp_valid !== oh || rsp_result !== exp_res || req_ready !== 2'b00) begin errors++; $display("FAIL rnd_hold_%0d got %b %h rdy %b exp %b %h 00", it, rsp_valid, rsp_result, req_ready, oh, exp_res); end
      end
      rsp_ready = rsp_ready | oh;
    end
    @(negedge clk);
    req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_lat3();
    int lat;
    @(negedge clk);
    req_opcode_3 = {8'h00, OP_ADD}; req_a_3 = {32'd0, 32'hFFFF_FFFF}; req_b_3 = {32'd0, 32'd1}; req_valid_3 = 2'b01;
    #1;
    checks++; if (req_ready_3 !== 2'b01) begin errors++; $display("FAIL lat3_grant got %b exp 01", req_ready_3); end
    @(posedge clk); #1;
    req_valid_3 = 2'b00; req_a_3 = {$urandom, $urandom}; req_opcode_3 = 16'h0202;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat <= 3) begin
        checks++;
        if (alu_opcode_3 !== OP_ADD || alu_a_3 !== 32'hFFFF_FFFF || alu_b_3 !== 32'd1) begin
          errors++; $display("FAIL lat3_alu_t%0d got %h %h %h exp 01 ffffffff 1", lat, alu_opcode_3, alu_a_3, alu_b_3);
        end
      end
    end while (rsp_valid_3 == 2'b00 && lat < 40);
    checks++; if (lat != 5) begin errors++; $display("FAIL lat3_latency got %0d exp 5", lat); end
    checks++; if (rsp_valid_3 !== 2'b01 || rsp_result_3 !== 32'd0 || rsp_err_3 !== 1'b0) begin errors++; $display("FAIL lat3_rsp got %b %h %b exp 01 0 0", rsp_valid_3, rsp_result_3, rsp_err_3); end
    @(negedge clk);
    checks++; if (busy_3 !== 1'b0) begin errors++; $display("FAIL lat3_done got busy %b exp 0", busy_3); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_arbitration();
    test_unsupported();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
